// File: rtl/csm_pkg.sv
// csm_pkg: shared types and helpers for the controlled shared memory (CSM) block.
//   cmd_t          - per-processor command encoding (NOP, READ, WRITE, HOLD, RELEASE)
//   lock_t         - lock ownership state (FREE, HELD_A, HELD_B)
//   NUM_REGS_DEF   - default register count
//   DATA_W_DEF     - default register width
//   cmds_conflict  - true when two simultaneous commands must be serialized
package csm_pkg;

    localparam int unsigned NUM_REGS_DEF = 4;
    localparam int unsigned DATA_W_DEF   = 8;

    typedef enum logic [2:0] {
        CmdNop     = 3'd0,
        CmdRead    = 3'd1,
        CmdWrite   = 3'd2,
        CmdHold    = 3'd3,
        CmdRelease = 3'd4
    } cmd_t;

    typedef enum logic [1:0] {
        LockFree  = 2'd0,
        LockHeldA = 2'd1,
        LockHeldB = 2'd2
    } lock_t;

    function automatic logic is_lock_cmd(input logic [2:0] cmd);
        return (cmd == CmdHold) || (cmd == CmdRelease);
    endfunction

    function automatic logic is_rw_cmd(input logic [2:0] cmd);
        return (cmd == CmdRead) || (cmd == CmdWrite);
    endfunction

    // Commands that are subject to the lock; NOP and undefined encodings are not.
    function automatic logic is_active_cmd(input logic [2:0] cmd);
        return is_lock_cmd(cmd) || is_rw_cmd(cmd);
    endfunction

    // Two lock commands always collide on the lock state; a write collides with any
    // read or write of the same register.
    function automatic logic cmds_conflict(input logic [2:0] cmd_a,
                                           input logic [2:0] cmd_b,
                                           input logic       same_addr);
        logic lock_pair;
        logic rw_pair;
        lock_pair = is_lock_cmd(cmd_a) && is_lock_cmd(cmd_b);
        rw_pair   = same_addr &&
                    (((cmd_a == CmdWrite) && is_rw_cmd(cmd_b)) ||
                     ((cmd_b == CmdWrite) && is_rw_cmd(cmd_a)));
        return lock_pair || rw_pair;
    endfunction

endpackage

// File: rtl/csm_lock_arb.sv
// csm_lock_arb: lock ownership FSM plus round-robin grant between ports A and B.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   a_req/a_cmd/a_addr    - port A command request
//   b_req/b_cmd/b_addr    - port B command request
//   grant_a, grant_b      - command executes on this clock edge
//   err_a, err_b          - granted command is rejected (lock violation / bad address)
//   lock_owner            - current lock_t state
module csm_lock_arb
    import csm_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        a_req,
    input  logic [2:0]                  a_cmd,
    input  logic [$clog2(NUM_REGS)-1:0] a_addr,
    input  logic                        b_req,
    input  logic [2:0]                  b_cmd,
    input  logic [$clog2(NUM_REGS)-1:0] b_addr,
    output logic                        grant_a,
    output logic                        grant_b,
    output logic                        err_a,
    output logic                        err_b,
    output logic [1:0]                  lock_owner
);

    lock_t lock_q, lock_d;
    logic  prio_q, prio_d;  // 0: A wins the next conflict, 1: B wins
    logic  conflict;
    logic  oor_a, oor_b;

    always_comb begin
        conflict = a_req && b_req && cmds_conflict(a_cmd, b_cmd, a_addr == b_addr);
        grant_a  = a_req && (!conflict || !prio_q);
        grant_b  = b_req && (!conflict || prio_q);
        // Loser of a conflict becomes the priority port so it cannot be starved.
        prio_d   = conflict ? ~prio_q : prio_q;

        oor_a = is_rw_cmd(a_cmd) && (32'(a_addr) >= NUM_REGS);
        oor_b = is_rw_cmd(b_cmd) && (32'(b_addr) >= NUM_REGS);
        err_a = grant_a && (((lock_q == LockHeldB) && is_active_cmd(a_cmd)) || oor_a);
        err_b = grant_b && (((lock_q == LockHeldA) && is_active_cmd(b_cmd)) || oor_b);

        lock_d = lock_q;
        case (lock_q)
            LockFree: begin
                // HOLD from both ports is a conflict, so at most one can be granted here.
                if (grant_a && !err_a && (a_cmd == CmdHold)) begin
                    lock_d = LockHeldA;
                end else if (grant_b && !err_b && (b_cmd == CmdHold)) begin
                    lock_d = LockHeldB;
                end
            end
            LockHeldA: begin
                if (grant_a && !err_a && (a_cmd == CmdRelease)) begin
                    lock_d = LockFree;
                end
            end
            LockHeldB: begin
                if (grant_b && !err_b && (b_cmd == CmdRelease)) begin
                    lock_d = LockFree;
                end
            end
            default: lock_d = LockFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= LockFree;
            prio_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            prio_q <= prio_d;
        end
    end

    assign lock_owner = lock_q;

endmodule

// File: rtl/csm_ctrl.sv
// csm_ctrl: dual-port controlled shared memory with hold/release locking.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   a_req/a_cmd/a_addr/a_wdata    - port A command, held until a_ack
//   a_ack/a_rdata/a_err           - port A registered response (one-cycle pulse)
//   b_*                           - same for port B
//   lock_owner                    - lock_t ownership state
//   err_count                     - saturating count of rejected commands
module csm_ctrl
    import csm_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        a_req,
    input  logic [2:0]                  a_cmd,
    input  logic [$clog2(NUM_REGS)-1:0] a_addr,
    input  logic [DATA_W-1:0]           a_wdata,
    output logic                        a_ack,
    output logic [DATA_W-1:0]           a_rdata,
    output logic                        a_err,
    input  logic                        b_req,
    input  logic [2:0]                  b_cmd,
    input  logic [$clog2(NUM_REGS)-1:0] b_addr,
    input  logic [DATA_W-1:0]           b_wdata,
    output logic                        b_ack,
    output logic [DATA_W-1:0]           b_rdata,
    output logic                        b_err,
    output logic [1:0]                  lock_owner,
    output logic [7:0]                  err_count
);

    logic              grant_a, grant_b, err_a, err_b;
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              a_wr, b_wr;
    logic [DATA_W-1:0] a_rdata_d, b_rdata_d;
    logic              a_ack_q, b_ack_q, a_err_q, b_err_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic [1:0]        err_inc;
    logic [8:0]        err_sum;
    logic [7:0]        err_count_q, err_count_d;

    csm_lock_arb #(
        .NUM_REGS (NUM_REGS)
    ) u_lock_arb (
        .clk        (clk),
        .reset      (reset),
        .a_req      (a_req),
        .a_cmd      (a_cmd),
        .a_addr     (a_addr),
        .b_req      (b_req),
        .b_cmd      (b_cmd),
        .b_addr     (b_addr),
        .grant_a    (grant_a),
        .grant_b    (grant_b),
        .err_a      (err_a),
        .err_b      (err_b),
        .lock_owner (lock_owner)
    );

    always_comb begin
        a_wr = grant_a && !err_a && (a_cmd == CmdWrite);
        b_wr = grant_b && !err_b && (b_cmd == CmdWrite);
        // Reads see the register contents before this edge's write.
        a_rdata_d = (grant_a && !err_a && (a_cmd == CmdRead)) ? mem_q[a_addr] : '0;
        b_rdata_d = (grant_b && !err_b && (b_cmd == CmdRead)) ? mem_q[b_addr] : '0;

        err_inc     = {1'b0, err_a} + {1'b0, err_b};
        err_sum     = {1'b0, err_count_q} + 9'(err_inc);
        err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // Same-address writes from both ports are serialized by the arbiter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            if (a_wr) mem_q[a_addr] <= a_wdata;
            if (b_wr) mem_q[b_addr] <= b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            err_count_q <= '0;
        end else begin
            a_ack_q     <= grant_a;
            b_ack_q     <= grant_b;
            a_err_q     <= err_a;
            b_err_q     <= err_b;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            err_count_q <= err_count_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign err_count = err_count_q;

endmodule
